line_rasterizer: RTL

Screen-space line rasterizer sitting directly downstream of `geometry_engine`. It accepts one projected edge per handshake, given as two integer screen vertices (x0,y0)→(x1,y1). It walks the edge with integer Bresenham stepping and emits one pixel coordinate per cycle on a valid/ready stream toward the framebuffer writer. Pixel output is stallable by downstream backpressure, and only one line is in flight at a time.

---
 rtl/line_rasterizer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/line_rasterizer.sv
// rtl/line_rasterizer.sv - Bresenham line rasterizer, one pixel per cycle on a stallable stream
//
// Accepts one edge (x0,y0)->(x1,y1) per handshake while idle, then walks it with
// integer Bresenham stepping and emits each pixel coordinate on a valid/ready stream.
//
// Parameters:
//   COORD_W   signed coordinate width (two's complement)
//   SCREEN_W  visible width, only used when LINE_RASTERIZER_CLIP_EN is defined
//   SCREEN_H  visible height, only used when LINE_RASTERIZER_CLIP_EN is defined
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_vtx_valid/o_vtx_ready  endpoint handshake (ready only while idle)
//   i_x0,i_y0,i_x1,i_y1      signed endpoints, captured on accept
//   o_px_valid/i_px_ready    pixel stream handshake
//   o_px_x,o_px_y,o_px_last  pixel coordinate and final-pixel flag
//   o_busy                   line in setup or stepping
//   o_done                   one-cycle pulse after the final pixel retires
//
// Optional feature macro: LINE_RASTERIZER_CLIP_EN drops off-screen pixels.

module line_rasterizer #(
  parameter int COORD_W  = 12,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_vtx_valid,
  output logic                      o_vtx_ready,
  input  logic signed [COORD_W-1:0] i_x0,
  input  logic signed [COORD_W-1:0] i_y0,
  input  logic signed [COORD_W-1:0] i_x1,
  input  logic signed [COORD_W-1:0] i_y1,
  output logic                      o_px_valid,
  input  logic                      i_px_ready,
  output logic signed [COORD_W-1:0] o_px_x,
  output logic signed [COORD_W-1:0] o_px_y,
  output logic                      o_px_last,
  output logic                      o_busy,
  output logic                      o_done
);

  // Two guard bits keep |dx|, |dy| and 2*err from overflowing.
  localparam int IW = COORD_W + 2;
  localparam logic signed [IW-1:0] ZERO = IW'(0);
  localparam logic signed [IW-1:0] P_ONE = IW'(1);
  localparam logic signed [IW-1:0] M_ONE = -IW'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STEP} state_t;
  state_t state, state_nxt;

  logic signed [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
  logic signed [IW-1:0]      dx_q, dy_q, sx_q, sy_q, err_q, cur_x_q, cur_y_q;
  logic                      at_end_q;

  logic signed [IW-1:0] x0e, y0e, x1e, y1e, ddx, ddy, abs_dx, neg_ady;
  logic signed [IW:0]   e2;
  logic signed [IW-1:0] nxt_x, nxt_y, nxt_err;
  logic                 nxt_end, setup_end, retire;
  logic                 vis_setup, vis_next;

  // Setup arithmetic from the captured endpoints.
  always_comb begin
    x0e       = IW'(x0_q);
    y0e       = IW'(y0_q);
    x1e       = IW'(x1_q);
    y1e       = IW'(y1_q);
    ddx       = x1e - x0e;
    ddy       = y1e - y0e;
    abs_dx    = ddx[IW-1] ? -ddx : ddx;
    neg_ady   = ddy[IW-1] ? ddy : -ddy;
    setup_end = (x0_q == x1_q) && (y0_q == y1_q);
  end

  // One Bresenham step; both axis decisions use the pre-step error.
  always_comb begin
    e2      = $signed({err_q, 1'b0});
    nxt_x   = cur_x_q;
    nxt_y   = cur_y_q;
    nxt_err = err_q;
    if (e2 >= dy_q) begin
      nxt_err = nxt_err + dy_q;
      nxt_x   = cur_x_q + sx_q;
    end
    if (e2 <= dx_q) begin
      nxt_err = nxt_err + dx_q;
      nxt_y   = cur_y_q + sy_q;
    end
    nxt_end = (nxt_x == x1e) && (nxt_y == y1e);
  end

`ifdef LINE_RASTERIZER_CLIP_EN
  function automatic logic on_screen(input logic signed [IW-1:0] x,
                                     input logic signed [IW-1:0] y);
    return (x >= ZERO) && (x < IW'(SCREEN_W)) && (y >= ZERO) && (y < IW'(SCREEN_H));
  endfunction
  assign vis_setup = on_screen(x0e, y0e);
  assign vis_next  = on_screen(nxt_x, nxt_y);
`else
  assign vis_setup = 1'b1;
  assign vis_next  = 1'b1;
`endif

  // A hidden (clipped) pixel retires on its own; a presented one waits for ready.
  assign retire      = (state == S_STEP) && (o_px_valid ? i_px_ready : 1'b1);
  assign o_vtx_ready = (state == S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_vtx_valid) state_nxt = S_SETUP;
      S_SETUP: state_nxt = S_STEP;
      S_STEP:  if (retire && at_end_q) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x0_q <= '0; y0_q <= '0; x1_q <= '0; y1_q <= '0;
      dx_q <= '0; dy_q <= '0; sx_q <= '0; sy_q <= '0;
      err_q <= '0; cur_x_q <= '0; cur_y_q <= '0; at_end_q <= 1'b0;
      o_px_valid <= 1'b0; o_px_last <= 1'b0;
      o_px_x <= '0; o_px_y <= '0;
      o_busy <= 1'b0; o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_vtx_valid) begin
            x0_q <= i_x0; y0_q <= i_y0; x1_q <= i_x1; y1_q <= i_y1;
            o_busy <= 1'b1;
          end
        end
        S_SETUP: begin
          dx_q       <= abs_dx;
          dy_q       <= neg_ady;
          sx_q       <= (ddx > ZERO) ? P_ONE : M_ONE;
          sy_q       <= (ddy > ZERO) ? P_ONE : M_ONE;
          err_q      <= abs_dx + neg_ady;
          cur_x_q    <= x0e;
          cur_y_q    <= y0e;
          at_end_q   <= setup_end;
          o_px_x     <= x0_q;
          o_px_y     <= y0_q;
          o_px_valid <= vis_setup;
          o_px_last  <= setup_end && vis_setup;
        end
        S_STEP: begin
          if (retire) begin
            if (at_end_q) begin
              o_px_valid <= 1'b0;
              o_px_last  <= 1'b0;
              o_busy     <= 1'b0;
              o_done     <= 1'b1;
            end else begin
              err_q      <= nxt_err;
              cur_x_q    <= nxt_x;
              cur_y_q    <= nxt_y;
              at_end_q   <= nxt_end;
              o_px_x     <= nxt_x[COORD_W-1:0];
              o_px_y     <= nxt_y[COORD_W-1:0];
              o_px_valid <= vis_next;
              o_px_last  <= nxt_end && vis_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
